// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 asynchronous serial receiver producing byte strobes
//
// Purpose: oversamples the serial line by clock count, frames 8N1 characters
// and presents each correctly framed byte as a one-cycle strobe.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   rx           raw serial line, asynchronous to clk, idle high
//   rx_byte      last correctly framed byte, held until the next good byte
//   rx_valid     one-cycle pulse, rx_byte valid in the same cycle
//   rx_frame_err one-cycle pulse, stop bit sampled low
//   rx_busy      high whenever the receiver is not idle

module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_BITS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    localparam logic [CNT_BITS-1:0] HALF = CNT_BITS'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(CLKS_PER_BIT - 1);
    localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

    logic                rx_meta_q, rx_s_q;
    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          rx_byte_q, rx_byte_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_frame_err_q, rx_frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer resets to the idle line level so reset never
            // fabricates a start edge on its own.
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_meta_q      <= rx;
            rx_s_q         <= rx_meta_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            rx_byte_q      <= rx_byte_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        rx_byte_d      = rx_byte_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                // Re-check the line mid start bit to reject short low glitches.
                if (cnt_q == HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    // LSB arrives first: shift right, newest bit enters at MSB.
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        state_d        = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_WAIT_HIGH: begin
                // A break or stuck-low line must return high before a new
                // start edge is recognised.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 9 * CPB + HALF + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_BITS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed pulse log: kind 1 = rx_valid, 2 = rx_frame_err.
    int         ev_cyc[$];
    logic [7:0] ev_byte[$];
    int         ev_kind[$];

    always @(negedge clk) begin
        if (rx_valid || rx_frame_err) begin
            ev_cyc.push_back(cyc);
            ev_byte.push_back(rx_byte);
            ev_kind.push_back(rx_valid ? 1 : 2);
            checks++;
            if (rx_valid && rx_frame_err) begin
                failures++;
                $display("FAIL pulse_exclusive valid=%0b ferr=%0b required not both", rx_valid, rx_frame_err);
            end
            if (rx_valid) begin
                checks++;
                if (rx_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_with_valid actual=%0b required=0", rx_busy);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clr_ev();
        ev_cyc.delete();
        ev_byte.delete();
        ev_kind.delete();
    endtask

    function automatic int count_kind(input int k);
        int n = 0;
        foreach (ev_kind[i]) if (ev_kind[i] == k) n++;
        return n;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    int         t0;
    int         last_valid_cyc;
    int         prev_gap;
    int         n;
    logic [7:0] b;
    logic       stop;
    int         gap;
    logic [7:0] last_good;
    int         exp_kind[$];
    logic [7:0] exp_byte[$];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 40, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1,  0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1,  0, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 40, 1, 0, 8'h3C};
        vecs[4] = '{8'h5A, 1'b1, 20, 1, 0, 8'h5A};
        vecs[5] = '{8'h7E, 1'b0, 30, 0, 1, 8'h5A};

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        chk("reset_byte", int'(rx_byte), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_ferr", int'(rx_frame_err), 0);
        chk("reset_busy", int'(rx_busy), 0);
        rst = 1'b0;
        tick(5);

        // Table-driven frames, including back-to-back with no idle gap
        last_valid_cyc = -1;
        prev_gap       = 1;
        for (int i = 0; i < NV; i++) begin
            clr_ev();
            t0 = cyc;
            send_frame(vecs[i].data, vecs[i].stop);
            rx = 1'b1;
            tick(vecs[i].gap);
            chk($sformatf("vec%0d_valid_cnt", i), count_kind(1), vecs[i].exp_valid);
            chk($sformatf("vec%0d_ferr_cnt", i), count_kind(2), vecs[i].exp_ferr);
            chk($sformatf("vec%0d_byte", i), int'(rx_byte), int'(vecs[i].exp_byte));
            if (vecs[i].exp_valid == 1 && ev_cyc.size() > 0) begin
                // t0 + 1 is the first edge that samples the line low
                chk_rng($sformatf("vec%0d_latency", i), ev_cyc[0] - (t0 + 1), LAT - 1, LAT + 1);
                chk($sformatf("vec%0d_ev_byte", i), int'(ev_byte[0]), int'(vecs[i].data));
                if (prev_gap == 0 && last_valid_cyc >= 0)
                    chk($sformatf("vec%0d_spacing", i), ev_cyc[0] - last_valid_cyc, 10 * CPB);
                last_valid_cyc = ev_cyc[0];
            end else begin
                last_valid_cyc = -1;
            end
            prev_gap = vecs[i].gap;
        end

        // Short low glitch on an idle line
        clr_ev();
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        n = 5;
        while (rx_busy && n < 4 * CPB) begin
            tick(1);
            n++;
        end
        chk_rng("glitch_busy_clear", n, 1, HALF + 4);
        tick(2 * CPB);
        chk("glitch_events", ev_kind.size(), 0);
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("post_glitch_valid", count_kind(1), 1);
        chk("post_glitch_byte", int'(rx_byte), 8'h5A);

        // Bad stop bit followed by a held-low line
        clr_ev();
        send_frame(8'h81, 1'b0);
        tick(40);
        chk("badstop_ferr_cnt", count_kind(2), 1);
        chk("badstop_valid_cnt", count_kind(1), 0);
        chk("badstop_byte_kept", int'(rx_byte), 8'h5A);
        chk("badstop_busy_low_line", int'(rx_busy), 1);
        rx = 1'b1;
        tick(10);
        chk("badstop_busy_released", int'(rx_busy), 0);
        clr_ev();
        send_frame(8'h42, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("after_break_valid", count_kind(1), 1);
        chk("after_break_byte", int'(rx_byte), 8'h42);

        // Reset during data bit 4
        clr_ev();
        b  = 8'hC3;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx  = 1'b1;
        chk("midreset_byte", int'(rx_byte), 0);
        chk("midreset_busy", int'(rx_busy), 0);
        tick(12 * CPB);
        chk("midreset_events", ev_kind.size(), 0);
        send_frame(8'h99, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("post_reset_valid", count_kind(1), 1);
        chk("post_reset_byte", int'(rx_byte), 8'h99);

        // Line low through reset deassertion: one framing error, then silence
        clr_ev();
        rx  = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        t0  = cyc;
        tick(300);
        chk("lowreset_ferr_cnt", count_kind(2), 1);
        chk("lowreset_valid_cnt", count_kind(1), 0);
        if (ev_cyc.size() > 0)
            chk_rng("lowreset_ferr_time", ev_cyc[0] - (t0 + 1), LAT - 1, LAT + 2);
        chk("lowreset_busy", int'(rx_busy), 1);
        rx = 1'b1;
        tick(10);
        chk("lowreset_busy_released", int'(rx_busy), 0);
        chk("lowreset_byte", int'(rx_byte), 0);

        // Randomized frames against a frame-level reference model
        clr_ev();
        exp_kind.delete();
        exp_byte.delete();
        last_good = 8'h00;
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(CPB, 2 * CPB));
            send_frame(b, stop);
            rx = 1'b1;
            tick(gap);
            if (stop) begin
                last_good = b;
                exp_kind.push_back(1);
                exp_byte.push_back(b);
            end else begin
                exp_kind.push_back(2);
                exp_byte.push_back(last_good);
            end
        end
        tick(2 * CPB);
        chk("rand_event_cnt", ev_kind.size(), exp_kind.size());
        if (ev_kind.size() == exp_kind.size()) begin
            foreach (exp_kind[i]) begin
                chk($sformatf("rand%0d_kind", i), ev_kind[i], exp_kind[i]);
                chk($sformatf("rand%0d_byte", i), int'(ev_byte[i]), int'(exp_byte[i]));
            end
        end
        chk("rand_final_byte", int'(rx_byte), int'(last_good));
        chk("rand_final_busy", int'(rx_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
